instruction_fetch_unit: RTL
===========================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: imem_req  output  1  fetch request to instruction memory.
REQ-004 SHALL have port: imem_addr  output  32  byte address of fetch, equal to current PC.
REQ-005 SHALL have port: imem_ready  input  1  memory returns data this cycle; meaningful only while imem_req=1.
REQ-006 SHALL have port: imem_rdata  input  32  fetched instruction word, sampled when imem_req & imem_ready.
REQ-007 SHALL have port: inst_valid  output  1  IR holds an instruction for the decode/control stage.
REQ-008 SHALL have port: inst  output  32  instruction register contents.
REQ-009 SHALL have port: part_of_inst  output  7  inst[6:0], the opcode field consumed by the control unit.
REQ-010 SHALL have port: inst_pc  output  32  PC of the instruction in IR.
REQ-011 SHALL have port: inst_ack  input  1  downstream has finished the current instruction; next_pc valid.
REQ-012 SHALL have port: next_pc  input  32  resolved next PC (pc+4, branch target, jal/jalr target).
REQ-013 SHALL have port: halt  input  1  ecall-halt condition for the current instruction, sampled with inst_ack.
REQ-014 SHALL have port: is_halted  output  1  fetch permanently stopped until reset.
REQ-015 SHALL have port: retire_count  output  32  number of acknowledged instructions.
REQ-016 SHALL have parameter: RESET_PC, default 32'h0, PC value loaded by reset.

Function
REQ-017 SHALL implement a three-state FSM: FETCH, VALID, HALTED.
REQ-018 In FETCH, SHALL drive imem_req=1 and imem_addr=PC, holding both stable until imem_ready=1.
REQ-019 In FETCH with imem_ready=1, SHALL load IR<=imem_rdata, inst_pc<=PC and enter VALID next cycle (one-cycle minimum fetch latency).
REQ-020 In FETCH with imem_ready=0, SHALL remain in FETCH; no limit on wait cycles.
REQ-021 In VALID, SHALL drive inst_valid=1, imem_req=0, and hold inst, part_of_inst and inst_pc constant until inst_ack.
REQ-022 In VALID with inst_ack=1 and halt=0, SHALL load PC<={next_pc[31:2],2'b00}, increment retire_count, and enter FETCH.
REQ-023 In VALID with inst_ack=1 and halt=1, SHALL increment retire_count, leave PC unchanged, and enter HALTED; halt has priority over redirect.
REQ-024 inst_ack or halt asserted outside VALID SHALL be ignored.
REQ-025 In HALTED, SHALL drive imem_req=0, inst_valid=0, is_halted=1, and remain there until reset.
REQ-026 imem_ready asserted while imem_req=0 SHALL be ignored.
REQ-027 part_of_inst SHALL be inst[6:0] combinationally; inst, inst_pc, part_of_inst SHALL be don't-care-free (hold last value) when inst_valid=0.
REQ-028 retire_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-029 PC arithmetic SHALL be 32-bit; next_pc low two bits SHALL be forced to zero, with no exception raised.

Reset
REQ-030 On reset=1 at a rising edge, SHALL set state=FETCH, PC=RESET_PC, IR=32'h0, inst_pc=RESET_PC, retire_count=0.
REQ-031 While reset=1, imem_req, inst_valid and is_halted SHALL be 0; the first request SHALL appear the cycle after reset deasserts.
REQ-032 Reset mid-fetch or in HALTED SHALL abandon the outstanding request and restart from RESET_PC; a late imem_ready is ignored.

Structure
REQ-033 FSM state encodings and default RESET_PC SHALL live in a shared defines include alongside the opcode definitions.
REQ-034 The PC register with synchronous reset and load enable SHALL be a sub-module named pc_register; the remainder is a single module.

Verification
REQ-035 Reset release, memory ready immediately with 32'h00500093 -> addr 0x0 in cycle 1, inst_valid cycle 2, part_of_inst=7'b0010011, inst_pc=0.
REQ-036 imem_ready held low 3 cycles at PC 0x4 -> imem_req/addr 0x4 stable 4 cycles, inst_valid only after the ready cycle.
REQ-037 inst_ack with next_pc=32'h0000_0102 -> next imem_addr=32'h0000_0100, retire_count +1.
REQ-038 inst_ack with halt=1 and next_pc=0x40 -> is_halted=1, imem_req stays 0 for 20 cycles, retire_count incremented, PC unchanged.
REQ-039 Reset asserted during FETCH wait at PC 0x20, imem_ready arrives while reset=1 -> IR not loaded, restart fetch at RESET_PC.
REQ-040 Spurious inst_ack during FETCH -> ignored: PC, retire_count and state unchanged.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, the default
// reset PC, RV32I major opcodes and a PC alignment helper.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_VALID  = 2'd1,
        ST_HALTED = 2'd2
    } ifu_state_e;

    // RV32I major opcodes (inst[6:0]) as seen by the control unit.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Misaligned targets are silently word-aligned rather than trapping.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter register: synchronous active-high reset to RESET_PC and a
// load enable; holds its value otherwise.
module pc_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] pc_d_i,
    output logic [31:0] pc_q_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = pc_d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_q_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: requests one word at PC, holds it in IR for decode
// until acknowledged, then follows next_pc or halts permanently until reset.
//
// Handshakes: a fetch completes on a rising edge where imem_req && imem_ready;
// an instruction retires on a rising edge where inst_valid && inst_ack (halt is
// sampled on that same edge). imem_ready with imem_req=0 and inst_ack/halt with
// inst_valid=0 are ignored.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [6:0]  part_of_inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ack,
    input  logic [31:0] next_pc,
    input  logic        halt,
    output logic        is_halted,
    output logic [31:0] retire_count,
    output logic [1:0]  dbg_state
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q;
    logic        pc_load;
    logic [31:0] ir_q, ir_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] retire_q, retire_d;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .reset  (reset),
        .load_i (pc_load),
        .pc_d_i (align_pc(next_pc)),
        .pc_q_o (pc_q)
    );

    always_comb begin
        state_d    = state_q;
        pc_load    = 1'b0;
        ir_d       = ir_q;
        inst_pc_d  = inst_pc_q;
        retire_d   = retire_q;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        is_halted  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d      = imem_rdata;
                    inst_pc_d = pc_q;
                    state_d   = ST_VALID;
                end
            end
            ST_VALID: begin
                inst_valid = 1'b1;
                if (inst_ack) begin
                    retire_d = retire_q + 32'd1;
                    // Halt wins over any redirect: PC stays on the halting instruction.
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_load = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALTED: begin
                is_halted = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Outputs are quiet for the whole reset window, not just after the first edge.
        if (reset) begin
            imem_req   = 1'b0;
            inst_valid = 1'b0;
            is_halted  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= 32'h0;
            inst_pc_q <= RESET_PC;
            retire_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            inst_pc_q <= inst_pc_d;
            retire_q  <= retire_d;
        end
    end

    assign imem_addr    = pc_q;
    assign inst         = ir_q;
    assign part_of_inst = ir_q[6:0];
    assign inst_pc      = inst_pc_q;
    assign retire_count = retire_q;
    assign dbg_state    = state_q;

endmodule
